// File: rtl/billiard_pkg.sv
// Shared types for the collision path: event codes, arbiter FSM states and the
// hole > ball-ball > wall priority pick. Bit i of a flag vector maps to event code i.
package billiard_pkg;

  typedef enum logic [1:0] {
    WALL     = 2'd0,
    BALLBALL = 2'd1,
    HOLE     = 2'd2
  } evt_code_t;

  typedef enum logic {
    StIdle  = 1'b0,
    StOffer = 1'b1
  } arb_state_t;

  localparam int unsigned NumTypes = 3;

  function automatic evt_code_t pick_highest(input logic [NumTypes-1:0] flags);
    if (flags[HOLE]) begin
      return HOLE;
    end else if (flags[BALLBALL]) begin
      return BALLBALL;
    end
    return WALL;
  endfunction

endpackage

// File: rtl/collision_latch.sv
// Per-frame collision detection: sticky collect flags per event type, restarted at
// every frame start so a hit in the frame-start cycle belongs to the new frame.
module collision_latch
  import billiard_pkg::*;
(
  input  logic                clk,
  input  logic                resetN,
  input  logic                i_sof,
  input  logic                i_req_ball,
  input  logic                i_req_wall,
  input  logic                i_req_other,
  input  logic                i_req_hole,
  output logic [NumTypes-1:0] o_collect
);

  logic [NumTypes-1:0] w_hit;
  logic [NumTypes-1:0] r_collect;

  assign w_hit[WALL]     = i_req_ball & i_req_wall;
  assign w_hit[BALLBALL] = i_req_ball & i_req_other;
  assign w_hit[HOLE]     = i_req_ball & i_req_hole;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_collect <= '0;
    end else if (i_sof) begin
      r_collect <= w_hit;
    end else begin
      r_collect <= r_collect | w_hit;
    end
  end

  assign o_collect = r_collect;

endmodule

// File: rtl/collision_arbiter.sv
// Collision event arbiter: snapshots per-frame hits into a pending set and offers
// them one at a time over a valid/ready handshake. COLLISION_TIMEOUT_EN adds an ack timeout.
module collision_arbiter
  import billiard_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       drawing_request_Ball,
  input  logic       drawing_request_Wall,
  input  logic       drawing_request_OtherBall,
  input  logic       drawing_request_Hole,
  input  logic       evt_ready,
  output logic       evt_valid,
  output logic [1:0] evt_code,
  output logic       any_hit_pulse,
  output logic       overrun,
  output logic       timeout_err
);

  logic [NumTypes-1:0] w_collect;
  logic [NumTypes-1:0] w_snap;
  logic [NumTypes-1:0] w_clear;
  logic [NumTypes-1:0] w_pending_d;
  logic [NumTypes-1:0] r_pending;
  arb_state_t          r_state, w_state_d;
  evt_code_t           r_code, w_code_d;
  logic                r_any_hit;
  logic                r_overrun;
  logic                w_xfer;
  logic                w_drop;

  collision_latch u_latch (
    .clk         (clk),
    .resetN      (resetN),
    .i_sof       (startOfFrame),
    .i_req_ball  (drawing_request_Ball),
    .i_req_wall  (drawing_request_Wall),
    .i_req_other (drawing_request_OtherBall),
    .i_req_hole  (drawing_request_Hole),
    .o_collect   (w_collect)
  );

  assign w_snap = startOfFrame ? w_collect : '0;
  assign w_xfer = (r_state == StOffer) && evt_ready;

`ifdef COLLISION_TIMEOUT_EN
  localparam int unsigned CntW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  logic [CntW-1:0] r_wait_cnt;

  // The drop fires in the ACK_TIMEOUT-th offer cycle without a ready.
  assign w_drop = (r_state == StOffer) && !evt_ready &&
                  (r_wait_cnt == CntW'(ACK_TIMEOUT - 1));

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_wait_cnt <= '0;
    end else if ((r_state == StOffer) && !evt_ready && !w_drop) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end else begin
      r_wait_cnt <= '0;
    end
  end

  assign timeout_err = w_drop;
`else
  assign w_drop      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Leaving OFFER always passes through IDLE, which yields the idle gap between events.
  always_comb begin
    w_state_d = r_state;
    w_code_d  = r_code;
    w_clear   = '0;
    unique case (r_state)
      StIdle: begin
        if (|r_pending) begin
          w_state_d = StOffer;
          w_code_d  = pick_highest(r_pending);
        end
      end
      StOffer: begin
        if (w_xfer || w_drop) begin
          w_clear[r_code] = 1'b1;
          w_state_d       = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
    w_pending_d = (r_pending & ~w_clear) | w_snap;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state   <= StIdle;
      r_code    <= WALL;
      r_pending <= '0;
      r_any_hit <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_code    <= w_code_d;
      r_pending <= w_pending_d;
      r_any_hit <= startOfFrame && (|w_collect);
      r_overrun <= startOfFrame && ((r_state == StOffer) || (|r_pending));
    end
  end

  assign evt_valid     = (r_state == StOffer);
  assign evt_code      = r_code;
  assign any_hit_pulse = r_any_hit;
  assign overrun       = r_overrun;

endmodule
